// File: rtl/div_seq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_unit_if
//  Purpose  : Request/result handshake bundle between the execute stage
//             (master) and the sequential divider (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface div_seq_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    // Request side
    logic             i_valid;
    logic             o_ready;
    logic [4:0]       i_alu_op;
    logic [XLEN-1:0]  i_operand_a;
    logic [XLEN-1:0]  i_operand_b;
    logic [TAG_W-1:0] i_tag;
    logic             o_busy;
    // Result side
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_valid, i_alu_op, i_operand_a, i_operand_b, i_tag, i_ready,
        input  o_ready, o_busy, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_valid, i_alu_op, i_operand_a, i_operand_b, i_tag, i_ready,
        output o_ready, o_busy, o_valid, o_result, o_tag
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_unit
//  Purpose  : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//             One quotient bit per cycle, MSB first, on operand magnitudes;
//             signs are restored combinationally at the output.
//  Options  : DIV_SPECIAL_FAST_EN - divide-by-zero and signed overflow skip
//             the iterative phase and complete at the accept edge.
//  Revision : 1.0 - initial release
// ============================================================================
module div_seq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    input  wire logic         i_flush,
    div_seq_unit_if.slave     bus
);

    localparam int              CNT_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_ONES     = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [1:0]        op_q, op_d;       // bit1: remainder, bit0: unsigned
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;

    // Request decode and special-case detection on the raw operands
    logic              w_is_div, w_signed, w_accept;
    logic              w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_spec_res;

    assign w_is_div  = (bus.i_alu_op[4:2] == 3'b101);
    assign w_signed  = ~bus.i_alu_op[0];
    assign w_accept  = bus.i_valid & (state_q == S_IDLE) & w_is_div & ~i_flush;
    assign w_a_neg   = w_signed & bus.i_operand_a[XLEN-1];
    assign w_b_neg   = w_signed & bus.i_operand_b[XLEN-1];
    assign w_b_zero  = (bus.i_operand_b == '0);
    assign w_ovf     = w_signed & (bus.i_operand_a == c_SMIN) & (bus.i_operand_b == c_ONES);
    assign w_special = w_b_zero | w_ovf;
    // Divide-by-zero takes priority, so its result never sees the sign fixup
    assign w_spec_res = w_b_zero ? (bus.i_alu_op[1] ? bus.i_operand_a : c_ONES)
                                 : (bus.i_alu_op[1] ? '0 : c_SMIN);

    // One restoring step: the shifted remainder keeps XLEN+1 bits so a
    // divisor with its MSB set still compares correctly
    logic [XLEN:0]     w_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;

    assign w_sh  = {rem_q, quo_q[XLEN-1]};
    assign w_ge  = (w_sh >= {1'b0, dvs_q});
    assign w_sub = w_sh[XLEN-1:0] - dvs_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush overrides everything, including a pending handoff
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (w_accept) begin
`ifdef DIV_SPECIAL_FAST_EN
                    state_d = w_special ? S_DONE : S_BUSY;
`else
                    state_d = S_BUSY;
`endif
                end
                S_BUSY: if (cnt_q == c_CNT_LAST) state_d = S_DONE;
                S_DONE: if (bus.i_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next-state: load magnitudes at accept, iterate while busy
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        op_d       = op_q;
        tag_d      = tag_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        if (w_accept) begin
            cnt_d      = '0;
            rem_d      = '0;
            quo_d      = w_a_neg ? -bus.i_operand_a : bus.i_operand_a;
            dvs_d      = w_b_neg ? -bus.i_operand_b : bus.i_operand_b;
            op_d       = bus.i_alu_op[1:0];
            tag_d      = bus.i_tag;
            neg_a_d    = w_a_neg;
            neg_b_d    = w_b_neg;
            spec_d     = w_special;
            spec_res_d = w_spec_res;
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q + 1'b1;
            rem_d = w_ge ? w_sub : w_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], w_ge};
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
        end
    end

    // Sign fixup and special-case override of the registered result
    logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_res;
    always_comb begin
        w_quo_fix = (~op_q[0] & ~op_q[1] & (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
        w_rem_fix = (~op_q[0] &  op_q[1] & neg_a_q) ? -rem_q : rem_q;
        w_res     = spec_q ? spec_res_q : (op_q[1] ? w_rem_fix : w_quo_fix);
    end

    assign bus.o_ready  = (state_q == S_IDLE);
    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_result = (state_q == S_DONE) ? w_res : '0;
    assign bus.o_tag    = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq_unit
//  Purpose  : Self-checking bench for div_seq_unit: vector table, random
//             unsigned/signed ops against a reference model, and hand-written
//             hold / flush / reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT_FULL = XLEN + 1;
`ifdef DIV_SPECIAL_FAST_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = XLEN + 1;
`endif

    localparam logic [4:0] OP_DIV  = 5'b10100;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110;
    localparam logic [4:0] OP_REMU = 5'b10111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    div_seq_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model using the language's truncating signed division
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV:  model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OP_REM:  model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            OP_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        bus.i_valid     = 1'b1;
        bus.i_alu_op    = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        bus.i_tag       = tag;
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
    endtask

    // Waits for o_valid; returns the cycle (accept cycle = 0) it was seen in
    task automatic wait_valid(output int cyc);
        int n;
        n = 0;
        while (!bus.o_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cyc = n + 1;
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat, input string nm);
        exp_t e;
        int   cyc;
        sb.push_back('{res: exp, tag: tag, lat: lat});
        issue(op, a, b, tag);
        chk({nm, " busy"}, 32'(bus.o_busy), 32'd1);
        wait_valid(cyc);
        e = sb.pop_front();
        chk({nm, " lat"}, 32'(cyc), 32'(e.lat));
        chk({nm, " res"}, bus.o_result, e.res);
        chk({nm, " tag"}, 32'(bus.o_tag), 32'(e.tag));
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        chk({nm, " idle"}, {30'd0, bus.o_ready, bus.o_valid}, 32'b10);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " valid"},  32'(bus.o_valid), 32'd0);
        chk({nm, " busy"},   32'(bus.o_busy),  32'd0);
        chk({nm, " ready"},  32'(bus.o_ready), 32'd1);
        chk({nm, " result"}, bus.o_result,     32'd0);
        chk({nm, " tag"},    32'(bus.o_tag),   32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int cyc;
        logic [31:0] held;
        logic        seen;
        bus.i_valid     = 1'b0;
        bus.i_alu_op    = 5'd0;
        bus.i_operand_a = '0;
        bus.i_operand_b = '0;
        bus.i_tag       = '0;
        bus.i_ready     = 1'b0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd9,  32'd14,         LAT_FULL};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd9,  32'd2,          LAT_FULL};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  LAT_FULL};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  LAT_FULL};
        vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd3,  32'd1,          LAT_FULL};
        vecs[5]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          5'd4,  32'hFFFF_FFFF,  LAT_SPEC};
        vecs[6]  = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd5,  32'hFFFF_FFF9,  LAT_SPEC};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,  LAT_SPEC};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0,          LAT_SPEC};
        vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd8,  32'hFFFF_FFFF,  LAT_FULL};
        vecs[10] = '{OP_REMU, 32'd5,          32'd0,          5'd10, 32'd5,          LAT_SPEC};
        vecs[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd11, 32'd1,          LAT_FULL};
        vecs[12] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD,  LAT_FULL};
        vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'd0,          LAT_FULL};

        // Reset state
        #1;
        chk_reset_outs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 14; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat,
                  $sformatf("vec%0d", i));

        // Random ops against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            int          lat;
            op  = 5'b10100 | 5'($urandom_range(0, 3));
            a   = $urandom;
            b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            lat = LAT_FULL;
            do_op(op, a, b, 5'(i + 13), model(op, a, b), lat, $sformatf("rnd%0d", i));
        end

        // Non-div opcode is ignored
        issue(5'b00000, 32'd9, 32'd3, 5'd1);
        chk("nondiv busy", 32'(bus.o_busy), 32'd0);

        // Result held while consumer stalls; new requests ignored
        sb.push_back('{res: 32'd100, tag: 5'd3, lat: LAT_FULL});
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd3);
        wait_valid(cyc);
        chk("hold lat", 32'(cyc), 32'(LAT_FULL));
        held = bus.o_result;
        for (int k = 0; k < 5; k++) begin
            bus.i_valid     = 1'b1;
            bus.i_alu_op    = OP_DIVU;
            bus.i_operand_a = 32'd1;
            bus.i_operand_b = 32'd1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid", k), 32'(bus.o_valid), 32'd1);
            chk($sformatf("hold%0d res", k),   bus.o_result,     held);
            chk($sformatf("hold%0d ready", k), 32'(bus.o_ready), 32'd0);
        end
        bus.i_valid = 1'b0;
        chk("hold res", held, sb.pop_front().res);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        chk("hold release", {30'd0, bus.o_ready, bus.o_valid}, 32'b10);
        @(posedge clk);
        #1;
        chk("hold no accept", 32'(bus.o_busy), 32'd0);

        // Flush in the middle of BUSY
        issue(OP_DIVU, 32'd12345, 32'd17, 5'd4);
        repeat (9) @(posedge clk);
        #1;
        chk("pre-flush busy", 32'(bus.o_busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy",  32'(bus.o_busy),  32'd0);
        chk("flush ready", 32'(bus.o_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.o_valid;
        end
        chk("flush no valid", 32'(seen), 32'd0);

        // Flush and request in the same cycle: nothing accepted
        @(negedge clk);
        flush           = 1'b1;
        bus.i_valid     = 1'b1;
        bus.i_alu_op    = OP_DIV;
        bus.i_operand_a = 32'd50;
        bus.i_operand_b = 32'd5;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush+valid busy", 32'(bus.o_busy), 32'd0);

        // Asynchronous reset in the middle of BUSY
        issue(OP_DIV, 32'hFFFF_0000, 32'd3, 5'd21);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(OP_REMU, 32'd100, 32'd7, 5'd9, 32'd2, LAT_FULL, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
